oneshot_arbiter: RTL

- Shares one dynamic-width pulse generator among N_REQ photon-channel trigger requesters.
- Per channel: captures trigger rising edges as pending events.
- Grants pending events round-robin and emits each as a single pulse of that channel's configured width on `pulse_out`.
- Enforces a programmable holdoff (dead time) between pulses.
- Sits between the channel discriminators and the shared pulse-shaping/readout path.

---
 rtl/oneshot_arbiter_if.sv | 41 ++++
 rtl/oneshot_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/oneshot_arbiter_if.sv
// Bus bundle for oneshot_arbiter: trigger requests, pulse config and status.
// Optional miss counter signals exist when ONESHOT_ARB_MISS_CNT_EN is defined.
interface oneshot_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 5,
    parameter int HOLD_W = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] width_cfg;
    logic [HOLD_W-1:0]      holdoff;
    logic                   enable;
    logic                   pulse_out;
    logic [N_REQ-1:0]       grant;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic [N_REQ-1:0]       pending;
`ifdef ONESHOT_ARB_MISS_CNT_EN
    logic                   miss_clr;
    logic [N_REQ*8-1:0]     miss_cnt;

    modport master (
        output req, width_cfg, holdoff, enable, miss_clr,
        input  pulse_out, grant, grant_id, busy, pending, miss_cnt
    );
    modport slave (
        input  req, width_cfg, holdoff, enable, miss_clr,
        output pulse_out, grant, grant_id, busy, pending, miss_cnt
    );
`else
    modport master (
        output req, width_cfg, holdoff, enable,
        input  pulse_out, grant, grant_id, busy, pending
    );
    modport slave (
        input  req, width_cfg, holdoff, enable,
        output pulse_out, grant, grant_id, busy, pending
    );
`endif
endinterface

// File: rtl/oneshot_arbiter.sv
// Round-robin one-shot arbiter sharing a single pulse generator among N_REQ channels.
// Optional per-channel lost-event counters: define ONESHOT_ARB_MISS_CNT_EN.
module oneshot_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 5,
    parameter int HOLD_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    oneshot_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   req_q;
    logic [N_REQ-1:0]   edg;
    logic [N_REQ-1:0]   pend_q, pend_d;
    logic [N_REQ-1:0]   take;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     sel;
    logic               found;
    logic [WIDTH-1:0]   w_sel;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
    logic               pulse_q, pulse_d;

    assign edg = bus.req & ~req_q;

    // Pick the first pending channel at or after the round-robin pointer.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && pend_q[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                sel   = IDW'((int'(ptr_q) + k) % N_REQ);
            end
        end
        w_sel = bus.width_cfg[int'(sel)*WIDTH +: WIDTH];
    end

    // Next-state and datapath updates for the grant / pulse / holdoff FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        pulse_d = pulse_q;
        gnt_d   = gnt_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        take    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && found) begin
                    take  = N_REQ'(1) << sel;
                    ptr_d = (sel == IDW'(N_REQ-1)) ? '0 : sel + IDW'(1);
                    // A zero width consumes the event without a pulse.
                    if (w_sel != '0) begin
                        state_d = PULSE;
                        cnt_d   = w_sel;
                        pulse_d = 1'b1;
                        gnt_d   = take;
                        gid_d   = sel;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == WIDTH'(1)) begin
                    pulse_d = 1'b0;
                    if (bus.holdoff != '0) begin
                        state_d = HOLD;
                        hcnt_d  = bus.holdoff;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            HOLD: begin
                if (hcnt_q == HOLD_W'(1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    hcnt_d = hcnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                pulse_d = 1'b0;
            end
        endcase
        // A new edge beats the clear of a channel granted this cycle.
        pend_d = (pend_q & ~take) | edg;
    end

    // State and datapath registers; req_q resets high to mask held triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '1;
            pend_q  <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= bus.req;
            pend_q  <= pend_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.grant     = gnt_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pending   = pend_q;

`ifdef ONESHOT_ARB_MISS_CNT_EN
    logic [N_REQ*8-1:0] miss_q;

    // Saturating count of edges dropped on an already-pending channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (bus.miss_clr) begin
            miss_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (edg[i] && pend_q[i] && !take[i] &&
                    miss_q[i*8 +: 8] != 8'hFF) begin
                    miss_q[i*8 +: 8] <= miss_q[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    assign bus.miss_cnt = miss_q;
`endif
endmodule
